add_seq_ctrl: RTL

Byte-serial multi-precision add sequencer. It time-shares one 8-bit carry-in adder across the NBYTES byte lanes of two wide operands and ripples the carry through a register between lanes. Operand bytes enter LSB-first over a valid/ready stream, and sum bytes leave over a registered valid/ready stream. The block sits between the tile's pin-level I/O mapping and the 8-bit adder datapath, and extends it to operands wider than 8 bits.

---
 rtl/add_seq_ctrl_pkg.sv | 12 +
 rtl/add8_ci.sv | 14 +
 rtl/add_seq_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial multi-precision add sequencer.
package add_seq_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/add8_ci.sv
// Shared 8-bit adder with carry-in; the one arithmetic resource every lane runs through.
module add8_ci
  import add_seq_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder: streams operand byte pairs LSB-first through add8_ci,
// carrying between lanes in a register and presenting sums on a registered stream.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] op_a,
  input  logic [BYTE_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] sum_byte,
  output logic              out_last,
  output logic              cout,
  output logic              busy
);

  localparam int LCW = $clog2(NBYTES) + 1;
  localparam logic [LCW-1:0] LAST_LANE = LCW'(NBYTES - 1);

  state_e            state_q, state_d;
  logic              carry_q, carry_d;
  logic [LCW-1:0]    lane_q, lane_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              cout_q, cout_d;

  logic [BYTE_W-1:0] add_sum;
  logic              add_co;
  logic              in_acc, out_hs, is_last;

  add8_ci u_add8 (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Free slot when the output register is empty or draining this cycle.
  assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_hs   = valid_q && out_ready;
  assign is_last  = (lane_q == LAST_LANE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d = state_q;
    carry_d = carry_q;
    lane_d  = lane_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    last_d  = last_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          carry_d = cin;
          lane_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_hs) valid_d = 1'b0;
        // An accept in the same cycle as a drain reloads the register.
        if (in_acc) begin
          sum_d   = add_sum;
          valid_d = 1'b1;
          carry_d = add_co;
          last_d  = is_last;
          cout_d  = is_last ? add_co : 1'b0;
          lane_d  = lane_q + 1'b1;
          if (is_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      carry_q <= 1'b0;
      lane_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      lane_q  <= lane_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign sum_byte  = sum_q;
  assign out_last  = last_q;
  assign cout      = cout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
